// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver. A start pulse arms one frame, and qualified bits are shifted in
// MSB- or LSB-first. The finished word is offered on a valid/ready output with a sticky overrun flag.
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             start,
  input  logic             msb_first,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             word_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] A_par,
  output logic             word_valid,
  output logic             busy,
  output logic             overrun,
  output logic             state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  // Output handshake: a word transfers on any edge where word_valid and word_ready are both high.
  // A_par is held until that edge. After it, A_par keeps its value while word_valid drops.

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    cnt;
  logic             order;
  logic             accept;
  logic             final_bit;
  logic             can_load;

  always_comb begin
    sr_next   = order ? {sr[WIDTH-2:0], bit_in} : {bit_in, sr[WIDTH-1:1]};
    // A start in RECV restarts the frame, so a bit on that same cycle is not taken.
    accept    = (state == RECV) && bit_valid && !start;
    final_bit = accept && (cnt == CW'(WIDTH - 1));
    // The new word can take the output slot if the slot is empty or is being emptied this edge.
    can_load  = !word_valid || word_ready;
  end

  assign state_dbg = (state == RECV);

  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      order      <= 1'b0;
      A_par      <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (word_valid && word_ready) word_valid <= 1'b0;
      if (clr_ovr) overrun <= 1'b0;

      if (start) begin
        state <= RECV;
        busy  <= 1'b1;
        cnt   <= '0;
        sr    <= '0;
        order <= msb_first;
      end else if (accept) begin
        sr <= sr_next;
        if (final_bit) begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
          // These assignments come after the handshake and clear updates above, so they win.
          if (can_load) begin
            A_par      <= sr_next;
            word_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH=4). Expected values are hand-computed, and each
// point is checked with an immediate assertion.
module tb_serial_word_receiver;

  localparam int WIDTH = 4;

  logic             CLK;
  logic             Clear;
  logic             start;
  logic             msb_first;
  logic             bit_valid;
  logic             bit_in;
  logic             word_ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] A_par;
  logic             word_valid;
  logic             busy;
  logic             overrun;
  logic             state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_word_receiver #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .Clear      (Clear),
    .start      (start),
    .msb_first  (msb_first),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .word_ready (word_ready),
    .clr_ovr    (clr_ovr),
    .A_par      (A_par),
    .word_valid (word_valid),
    .busy       (busy),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [WIDTH-1:0] e_par, input logic e_wv,
                           input logic e_busy, input logic e_ovr);
    check({tag, ".A_par"},      {12'b0, A_par},      {12'b0, e_par});
    check({tag, ".word_valid"}, {15'b0, word_valid}, {15'b0, e_wv});
    check({tag, ".busy"},       {15'b0, busy},       {15'b0, e_busy});
    check({tag, ".overrun"},    {15'b0, overrun},    {15'b0, e_ovr});
  endtask

  task automatic start_frame(input logic order);
    start     = 1'b1;
    msb_first = order;
    step();
    start     = 1'b0;
    msb_first = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  initial begin
    Clear = 1'b0; start = 1'b0; msb_first = 1'b0; bit_valid = 1'b0;
    bit_in = 1'b0; word_ready = 1'b0; clr_ovr = 1'b0;
    step();
    check_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    check("reset.state_dbg", {15'b0, state_dbg}, 16'h0);
    Clear = 1'b1;
    step();

    // Bits offered in IDLE without a start are ignored.
    send_bit(1'b1);
    check_out("idle_bits", 4'b0000, 1'b0, 1'b0, 1'b0);

    // MSB first: 1,0,1,1 gives 1011.
    start_frame(1'b1);
    check("msb.busy_after_start", {15'b0, busy}, 16'h1);
    check("msb.state_dbg", {15'b0, state_dbg}, 16'h1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("msb.no_valid_before_last", {15'b0, word_valid}, 16'h0);
    send_bit(1'b1);
    check_out("msb", 4'b1011, 1'b1, 1'b0, 1'b0);

    // Overrun: 0,1,1,0 completes while 1011 is still held, so 1011 stays.
    start_frame(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check_out("overrun", 4'b1011, 1'b1, 1'b0, 1'b1);
    step();
    check("overrun.sticky", {15'b0, overrun}, 16'h1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check_out("clr_ovr", 4'b1011, 1'b1, 1'b0, 1'b0);

    // Back-to-back accept: 0110 completes on the same edge that takes 1011.
    start_frame(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    word_ready = 1'b1;
    send_bit(1'b0);
    word_ready = 1'b0;
    check_out("b2b", 4'b0110, 1'b1, 1'b0, 1'b0);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    check_out("consume", 4'b0110, 1'b0, 1'b0, 1'b0);

    // LSB first with gaps: 1,0,1,1 gives 1101.
    start_frame(1'b0);
    send_bit(1'b1); step();
    send_bit(1'b0); step(); step();
    send_bit(1'b1); step();
    check("lsb.busy_in_gap", {15'b0, busy}, 16'h1);
    check("lsb.no_valid_in_gap", {15'b0, word_valid}, 16'h0);
    send_bit(1'b1);
    check_out("lsb_gaps", 4'b1101, 1'b1, 1'b0, 1'b0);

    // A set of overrun wins over clr_ovr arriving on the same edge.
    start_frame(1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    clr_ovr = 1'b1;
    send_bit(1'b1);
    clr_ovr = 1'b0;
    check_out("ovr_priority", 4'b1101, 1'b1, 1'b0, 1'b1);
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
    word_ready = 1'b1; step(); word_ready = 1'b0;
    check_out("drain", 4'b1101, 1'b0, 1'b0, 1'b0);

    // Abort: restart after 2 bits, with a bit offered on the restart cycle; then 0,0,0,1 gives 0001.
    start_frame(1'b1);
    send_bit(1'b1); send_bit(1'b1);
    start = 1'b1; msb_first = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    start = 1'b0; msb_first = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    check("abort.busy", {15'b0, busy}, 16'h1);
    check("abort.no_valid", {15'b0, word_valid}, 16'h0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    check_out("abort", 4'b0001, 1'b1, 1'b0, 1'b0);

    // Make overrun high, then assert reset mid-frame with every output nonzero.
    start_frame(1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check_out("pre_reset_ovr", 4'b0001, 1'b1, 1'b0, 1'b1);
    start_frame(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("pre_reset.busy", {15'b0, busy}, 16'h1);
    #2 Clear = 1'b0;
    #1;
    check_out("async_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    Clear = 1'b1;
    step();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check_out("post_reset_no_start", 4'b0000, 1'b0, 1'b0, 1'b0);

    // After reset, a new frame is received normally. LSB first 0,1,1,1 gives 1110.
    start_frame(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check_out("recover", 4'b1110, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the parallel word width in bits; the legal range is 2..16.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port Clear  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  frame start; a single-cycle pulse that arms reception of one word.
REQ-005 SHALL have port msb_first  input  1  bit order: 1 = MSB first, 0 = LSB first; sampled only on the start cycle.
REQ-006 SHALL have port bit_valid  input  1  qualifies bit_in on the current cycle.
REQ-007 SHALL have port bit_in  input  1  serial data bit.
REQ-008 SHALL have port word_ready  input  1  consumer accepts A_par when it is high together with word_valid.
REQ-009 SHALL have port clr_ovr  input  1  synchronous clear of the overrun flag.
REQ-010 SHALL have port A_par  output  WIDTH  received parallel word, registered.
REQ-011 SHALL have port word_valid  output  1  A_par holds an unconsumed word.
REQ-012 SHALL have port busy  output  1  high while in RECV.
REQ-013 SHALL have port overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-014 SHALL implement an FSM with the states IDLE and RECV.
REQ-015 SHALL treat bit_valid as don't-care in IDLE.
REQ-016 SHALL leave IDLE only on start=1.
REQ-017 SHALL, on start in IDLE, on the next edge:
- enter RECV;
- clear the bit counter;
- clear the shift register;
- latch msb_first into an internal order bit.
REQ-018 SHALL, in RECV on each edge with bit_valid=1, shift according to the latched order bit:
- order=1: the shift register becomes {sr[WIDTH-2:0], bit_in} (left shift, insert at LSB);
- order=0: the shift register becomes {bit_in, sr[WIDTH-1:1]} (right shift, insert at MSB).
REQ-019 SHALL, in RECV, hold the shift register and bit counter when bit_valid=0; there is no timeout.
REQ-020 SHALL use a bit counter of width clog2(WIDTH+1).
REQ-021 SHALL increment the bit counter on each accepted bit.
REQ-022 SHALL treat the bit accepted when the count equals WIDTH-1 as the final bit of the word.
REQ-023 SHALL return to IDLE on the edge that accepts the final bit.
REQ-024 SHALL, on that same final-bit edge, either load the completed word into A_par with word_valid=1, or drop it per REQ-029.
REQ-025 SHALL make A_par valid one edge after the final bit; the latency from start to word_valid is at least WIDTH+1 cycles.
REQ-026 SHALL, when start=1 in RECV, abort the current frame:
- discard the partial word;
- clear the bit counter;
- re-latch msb_first;
- stay in RECV;
- ignore any bit_valid on that cycle.
REQ-027 SHALL hold A_par and word_valid stable until word_valid & word_ready is true at an edge.
REQ-028 SHALL clear word_valid after that handshake edge; A_par retains its last value.
REQ-029 SHALL handle a word completing while word_valid=1 as follows:
- if word_ready=1 on the same cycle: load the new word and keep word_valid=1 (back-to-back accept);
- otherwise: keep the old word, drop the new one, and set overrun=1.
REQ-030 SHALL keep overrun at 1 until clr_ovr=1 at an edge.
REQ-031 SHALL give overrun set priority over clr_ovr when both occur on the same edge.
REQ-032 SHALL assert busy exactly while the state is RECV.
REQ-033 SHALL never change A_par except by a word load or by reset.

Reset
REQ-034 SHALL, when Clear=0, asynchronously and immediately force:
- state = IDLE;
- shift register = 0;
- bit counter = 0;
- order bit = 0;
- A_par = 0;
- word_valid = 0;
- busy = 0;
- overrun = 0.
REQ-035 SHALL discard any partial frame on reset; after release, the block requires a new start.
REQ-036 SHALL be released from reset synchronously to the first CLK edge with Clear=1; no output glitches on release.

Verification
REQ-037 SHALL cover MSB-first reception: WIDTH=4, start with msb_first=1, bits 1,0,1,1 on consecutive cycles, word_ready=0 -> A_par=4'b1011, word_valid=1 one edge after the 4th bit, busy=0.
REQ-038 SHALL cover LSB-first reception with gaps: msb_first=0, bits 1,0,1,1 with bit_valid=0 gaps between them -> A_par=4'b1101; the gaps do not change the count.
REQ-039 SHALL cover overrun: after the first word is held with word_ready=0, a second frame of 0,1,1,0 -> A_par stays 4'b1011, overrun=1; then clr_ovr=1 -> overrun=0.
REQ-040 SHALL cover back-to-back accept: a second word completes with word_ready=1 on the same cycle -> A_par=4'b0110, word_valid stays 1, overrun stays 0.
REQ-041 SHALL cover abort: start re-asserted after 2 bits, then 4 bits 0,0,0,1 (MSB first) -> A_par=4'b0001; the partial bits are absent.
REQ-042 SHALL cover reset mid-frame: Clear=0 after 3 bits -> all outputs 0 at once; after release, bits without start -> no word_valid.
